// File: rtl/frame_unpacker_pkg.sv
`default_nettype none
// ============================================================================
// Module   : frame_unpacker_pkg
// Brief    : Frame geometry and FSM encoding shared by the frame unpacker.
// Revision : 1.0
// ============================================================================
package frame_unpacker_pkg;

    localparam int FRAME_W       = 512;
    localparam int FRAME_H       = 424;
    localparam int FRAME_PIXELS  = FRAME_W * FRAME_H;
    localparam int FRAME_LOGSIZE = 18;
    localparam int FRAME_BYTES   = FRAME_PIXELS / 8;

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_RUN  = 1'b1;

    typedef struct packed {
        logic sync_err;
        logic short_frame;
    } err_flags_t;

endpackage
`default_nettype wire

// File: rtl/frame_unpacker_if.sv
`default_nettype none
// ============================================================================
// Module   : frame_unpacker_if
// Brief    : Packed byte stream in, pixel BRAM write port and status out.
// Revision : 1.0
// ============================================================================
interface frame_unpacker_if
    import frame_unpacker_pkg::*;
#(
    parameter int LOGSIZE = FRAME_LOGSIZE
) ();

    logic [7:0]         byte_data;
    logic               byte_valid;
    logic               byte_sof;
    logic               byte_ready;
    logic [LOGSIZE-1:0] wr_addr;
    logic               wr_din;
    logic               wr_we;
    logic               buf_sel;
    logic               frame_done;
    logic [15:0]        frame_count;
    logic               sync_err;
    logic               short_frame;

    modport master (
        output byte_data, byte_valid, byte_sof,
        input  byte_ready, wr_addr, wr_din, wr_we, buf_sel,
        input  frame_done, frame_count, sync_err, short_frame
    );

    modport slave (
        input  byte_data, byte_valid, byte_sof,
        output byte_ready, wr_addr, wr_din, wr_we, buf_sel,
        output frame_done, frame_count, sync_err, short_frame
    );

endinterface
`default_nettype wire

// File: rtl/frame_unpacker_byte_serializer.sv
`default_nettype none
// ============================================================================
// Module   : byte_serializer
// Brief    : Shifts a loaded byte out LSB first, one bit per cycle.
// Revision : 1.0
// ============================================================================
module byte_serializer (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_load,
    input  logic [7:0] i_data,
    output logic       o_bit,
    output logic       o_pending,
    output logic       o_last,
    output logic       o_ready
);

    logic [7:0] r_shift;
    logic [2:0] r_cnt;
    logic       r_pending;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift   <= '0;
            r_cnt     <= '0;
            r_pending <= 1'b0;
        end else if (i_load) begin
            r_shift   <= i_data;
            r_cnt     <= '0;
            r_pending <= 1'b1;
        end else if (r_pending) begin
            r_shift <= {1'b0, r_shift[7:1]};
            r_cnt   <= r_cnt + 3'd1;
            if (r_cnt == 3'd7) begin
                r_pending <= 1'b0;
            end
        end
    end

    assign o_bit     = r_shift[0];
    assign o_pending = r_pending;
    assign o_last    = r_pending && (r_cnt == 3'd7);
    // Accepting during the 8th bit lets the next byte follow without a bubble.
    assign o_ready   = !r_pending || o_last;

endmodule
`default_nettype wire

// File: rtl/frame_unpacker.sv
`default_nettype none
// ============================================================================
// Module   : frame_unpacker
// Brief    : Unpacks 8-pixel bytes into per-pixel frame BRAM writes.
// Revision : 1.0
// ============================================================================
module frame_unpacker
    import frame_unpacker_pkg::*;
#(
    parameter int SIZE    = FRAME_PIXELS,
    parameter int LOGSIZE = FRAME_LOGSIZE
) (
    input logic             clk,
    input logic             reset,
    frame_unpacker_if.slave bus
);

    localparam logic [LOGSIZE-1:0] c_last_addr = LOGSIZE'(SIZE - 1);

    logic [0:0]         r_state;
    logic [LOGSIZE-1:0] r_addr;
    logic               r_buf_sel;
    logic               r_frame_done;
    logic [15:0]        r_frame_count;
    err_flags_t         r_flags;

    logic w_accept;
    logic w_load;
    logic w_frame_end;
    logic w_ready;
    logic w_ser_bit;
    logic w_ser_pending;
    logic w_ser_last;
    logic w_ser_ready;

    assign w_accept    = bus.byte_valid && w_ready;
    // Non-SOF bytes seen while idle are swallowed, never serialized.
    assign w_load      = w_accept && (bus.byte_sof || (r_state == c_ST_RUN));
    assign w_frame_end = (r_state == c_ST_RUN) && w_ser_last && (r_addr == c_last_addr);
    assign w_ready     = w_ser_ready && !w_frame_end && !reset;

    byte_serializer u_ser (
        .clk       (clk),
        .rst       (reset),
        .i_load    (w_load),
        .i_data    (bus.byte_data),
        .o_bit     (w_ser_bit),
        .o_pending (w_ser_pending),
        .o_last    (w_ser_last),
        .o_ready   (w_ser_ready)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= c_ST_IDLE;
            r_addr        <= '0;
            r_buf_sel     <= 1'b0;
            r_frame_done  <= 1'b0;
            r_frame_count <= '0;
            r_flags       <= '0;
        end else begin
            r_frame_done <= 1'b0;
            if (r_state == c_ST_IDLE) begin
                if (w_accept) begin
                    if (bus.byte_sof) begin
                        r_state <= c_ST_RUN;
                        r_addr  <= '0;
                    end else begin
                        r_flags.sync_err <= 1'b1;
                    end
                end
            end else if (w_frame_end) begin
                r_state       <= c_ST_IDLE;
                r_frame_done  <= 1'b1;
                r_buf_sel     <= ~r_buf_sel;
                r_frame_count <= r_frame_count + 16'd1;
            end else if (w_accept && bus.byte_sof) begin
                r_addr              <= '0;
                r_flags.short_frame <= 1'b1;
            end else if (w_accept || (w_ser_pending && !w_ser_last)) begin
                // On a byte gap the address parks on the last written pixel.
                r_addr <= r_addr + LOGSIZE'(1);
            end
        end
    end

    assign bus.byte_ready  = w_ready;
    assign bus.wr_addr     = r_addr;
    assign bus.wr_din      = w_ser_bit;
    assign bus.wr_we       = w_ser_pending;
    assign bus.buf_sel     = r_buf_sel;
    assign bus.frame_done  = r_frame_done;
    assign bus.frame_count = r_frame_count;
    assign bus.sync_err    = r_flags.sync_err;
    assign bus.short_frame = r_flags.short_frame;

endmodule
`default_nettype wire

// File: tb/tb_frame_unpacker.sv
`default_nettype none
// ============================================================================
// Module   : tb_frame_unpacker
// Brief    : Scoreboard bench for frame_unpacker on a reduced 2048-pixel frame.
// Revision : 1.0
// ============================================================================
module tb_frame_unpacker;

    localparam int SIZE  = 2048;
    localparam int LS    = 11;
    localparam int BYTES = SIZE / 8;

    typedef struct {
        logic [LS-1:0] addr;
        logic          din;
    } wr_t;

    logic clk;
    logic reset;
    int   cyc;
    int   checks;
    int   errors;
    int   t_sof;

    wr_t  exp_q[$];
    wr_t  mon_e;
    logic have_last;
    logic prev_end;
    logic [LS-1:0] last_addr;

    logic        m_run;
    int          m_next;
    logic        m_buf;
    logic [15:0] m_count;
    logic        m_sync;
    logic        m_short;

    frame_unpacker_if #(.LOGSIZE(LS)) bus ();

    frame_unpacker #(.SIZE(SIZE), .LOGSIZE(LS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_run = 1'b0; m_next = 0; m_buf = 1'b0; m_count = '0;
        m_sync = 1'b0; m_short = 1'b0;
    endtask

    task automatic model_accept(input logic [7:0] d, input logic sof);
        int base;
        wr_t w;
        if (sof) begin
            if (m_run) m_short = 1'b1;
            m_run = 1'b1;
            base  = 0;
        end else if (!m_run) begin
            m_sync = 1'b1;
            return;
        end else begin
            base = m_next;
        end
        for (int i = 0; i < 8; i++) begin
            w.addr = LS'(base + i);
            w.din  = d[i];
            exp_q.push_back(w);
        end
        m_next = base + 8;
        if (m_next == SIZE) begin
            m_run   = 1'b0;
            m_count = m_count + 16'd1;
            m_buf   = ~m_buf;
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [7:0] d, input logic sof, input logic slotted);
        int t;
        t = 0;
        bus.byte_data  = d;
        bus.byte_sof   = sof;
        bus.byte_valid = !slotted || (cyc % 3 == 0);
        while (!(bus.byte_ready === 1'b1 && bus.byte_valid) && t < 64) begin
            @(negedge clk);
            t++;
            bus.byte_valid = !slotted || (cyc % 3 == 0);
        end
        checks++;
        assert (t < 64) else begin
            errors++;
            $error("FAIL accept_timeout: waited %0d cycles, expected fewer than 64", t);
        end
        if (t < 64) begin
            if (sof) t_sof = cyc;
            model_accept(d, sof);
        end
        @(negedge clk);
        bus.byte_valid = 1'b0;
        bus.byte_sof   = 1'b0;
    endtask

    task automatic send_frame(input int nbytes, input logic use_a5, input logic slotted);
        for (int i = 0; i < nbytes; i++) begin
            send(use_a5 ? 8'hA5 : 8'($urandom), (i == 0), slotted);
        end
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (bus.frame_done !== 1'b1 && t < 32) begin
            @(negedge clk);
            t++;
        end
        checks++;
        assert (t < 32) else begin
            errors++;
            $error("FAIL done_timeout: waited %0d cycles, expected frame_done within 32", t);
        end
    endtask

    task automatic check_status(input string tag);
        chk({tag, "_buf_sel"},     32'(bus.buf_sel),     32'(m_buf));
        chk({tag, "_frame_count"}, 32'(bus.frame_count), 32'(m_count));
        chk({tag, "_sync_err"},    32'(bus.sync_err),    32'(m_sync));
        chk({tag, "_short_frame"}, 32'(bus.short_frame), 32'(m_short));
        chk({tag, "_queue_empty"}, 32'(exp_q.size()),    32'd0);
    endtask

    initial begin
        checks = 0; errors = 0; t_sof = 0;
        have_last = 1'b0; prev_end = 1'b0; last_addr = '0;
        reset = 1'b1;
        bus.byte_data = '0; bus.byte_valid = 1'b0; bus.byte_sof = 1'b0;
        model_reset();

        fork
            forever begin
                @(negedge clk);
                if (reset !== 1'b0) begin
                    have_last = 1'b0;
                    prev_end  = 1'b0;
                end else begin
                    checks++;
                    assert (bus.frame_done === prev_end) else begin
                        errors++;
                        $error("FAIL frame_done_pulse: observed %b, expected %b", bus.frame_done, prev_end);
                    end
                    if (bus.wr_we === 1'b1) begin
                        checks++;
                        assert (exp_q.size() > 0) else begin
                            errors++;
                            $error("FAIL unexpected_write: observed write at addr %0d, expected none", bus.wr_addr);
                        end
                        if (exp_q.size() > 0) begin
                            mon_e = exp_q.pop_front();
                            checks++;
                            assert (bus.wr_addr === mon_e.addr && bus.wr_din === mon_e.din) else begin
                                errors++;
                                $error("FAIL pixel_write: observed addr %0d din %b, expected addr %0d din %b",
                                       bus.wr_addr, bus.wr_din, mon_e.addr, mon_e.din);
                            end
                        end
                        have_last = 1'b1;
                        last_addr = bus.wr_addr;
                        prev_end  = (bus.wr_addr == LS'(SIZE - 1));
                    end else begin
                        prev_end = 1'b0;
                        if (have_last) begin
                            checks++;
                            assert (bus.wr_addr === last_addr) else begin
                                errors++;
                                $error("FAIL addr_hold: observed %0d, expected %0d", bus.wr_addr, last_addr);
                            end
                        end
                    end
                end
            end
        join_none

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_byte_ready", 32'(bus.byte_ready), 32'd0);
        chk("rst_wr_we",      32'(bus.wr_we),      32'd0);
        chk("rst_wr_addr",    32'(bus.wr_addr),    32'd0);
        chk("rst_wr_din",     32'(bus.wr_din),     32'd0);
        chk("rst_frame_done", 32'(bus.frame_done), 32'd0);
        check_status("rst");
        reset = 1'b0;
        #1;
        chk("rel_byte_ready", 32'(bus.byte_ready), 32'd1);
        @(negedge clk);

        // Full frame of 0xA5 at continuous valid
        send_frame(BYTES, 1'b1, 1'b0);
        wait_done();
        chk("full_latency", 32'(cyc - t_sof), 32'(SIZE + 1));
        check_status("full");

        // SOF on byte 100 restarts the frame
        send_frame(100, 1'b0, 1'b0);
        send(8'($urandom), 1'b1, 1'b0);
        chk("mid_short_frame", 32'(bus.short_frame), 32'd1);
        chk("mid_buf_sel",     32'(bus.buf_sel),     32'd1);
        for (int i = 1; i < BYTES; i++) send(8'($urandom), 1'b0, 1'b0);
        wait_done();
        check_status("mid");

        // byte_valid only on one cycle in three
        send_frame(BYTES, 1'b0, 1'b1);
        wait_done();
        check_status("irregular");

        // Two frames back to back
        send_frame(BYTES, 1'b0, 1'b0);
        send_frame(BYTES, 1'b0, 1'b0);
        wait_done();
        chk("b2b_latency", 32'(cyc - t_sof), 32'(SIZE + 1));
        check_status("b2b");

        // Reset in the middle of a frame
        send_frame(50, 1'b0, 1'b0);
        #1;
        reset = 1'b1;
        #1;
        chk("mrst_wr_we",       32'(bus.wr_we),       32'd0);
        chk("mrst_wr_addr",     32'(bus.wr_addr),     32'd0);
        chk("mrst_wr_din",      32'(bus.wr_din),      32'd0);
        chk("mrst_byte_ready",  32'(bus.byte_ready),  32'd0);
        chk("mrst_buf_sel",     32'(bus.buf_sel),     32'd0);
        chk("mrst_frame_count", 32'(bus.frame_count), 32'd0);
        exp_q.delete();
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mrst_rel_ready", 32'(bus.byte_ready), 32'd1);
        check_status("mrst");
        @(negedge clk);

        // Junk bytes while idle, then a clean frame
        for (int i = 0; i < 5; i++) send(8'($urandom), 1'b0, 1'b0);
        chk("junk_sync_err", 32'(bus.sync_err), 32'd1);
        chk("junk_wr_we",    32'(bus.wr_we),    32'd0);
        send_frame(BYTES, 1'b0, 1'b0);
        wait_done();
        check_status("after_junk");

        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
